// File: rtl/soundmix_ma.sv
// Audio mixer: NCH one-bit pulse channels (optionally moving-average filtered) plus PCM,
// decimated to one OUT_W sample per DECIM clocks, and a Schmitt-triggered tape input.
module soundmix_ma #(
  parameter int unsigned     NCH        = 4,
  parameter logic [NCH-1:0]  FILT_MASK  = 4'b0111,
  parameter int unsigned     LOG2DEPTH  = 2,
  parameter int unsigned     DECIM      = 256,
  parameter int unsigned     CH_SHIFT   = 12,
  parameter int unsigned     PCM_W      = 8,
  parameter int unsigned     PCM_SHIFT  = 5,
  parameter int unsigned     OUT_W      = 16,
  parameter bit              OUT_SIGNED = 1'b0,
  parameter int unsigned     HYST       = 4
) (
  input  logic              clk18,
  input  logic              reset_n,
  input  logic [NCH-1:0]    pulses,
  input  logic [NCH-1:0]    chan_mute,
  input  logic [PCM_W-1:0]  pcm,
  input  logic [15:0]       linein,
  output logic [OUT_W-1:0]  audio_out,
  output logic              sample_stb,
  output logic              clip,
  output logic              tapein
);

  localparam int unsigned DEPTH  = 1 << LOG2DEPTH;
  localparam int unsigned DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned NF_W   = $clog2(NCH + 1);
  localparam int unsigned SUM_W  = $clog2(NCH * DEPTH + 1);
  localparam int unsigned MIX_W  = OUT_W + 2;

  localparam logic [OUT_W-1:0] OUT_RST = OUT_SIGNED ? {1'b1, {(OUT_W-1){1'b0}}} : '0;
  localparam logic [8:0]       TAPE_HI = 9'(128 + HYST);
  localparam logic [8:0]       TAPE_LO = 9'(128 - HYST);

  logic [DCNT_W-1:0]            dcnt_q, dcnt_d;
  logic [DEPTH-1:0][NF_W-1:0]   dly_q, dly_d;
  logic [SUM_W-1:0]             sum_q, sum_d;
  logic [OUT_W-1:0]             audio_out_q, audio_out_d;
  logic                         clip_q, clip_d;
  logic                         sample_stb_q, sample_stb_d;
  logic                         tapein_q, tapein_d;

  logic                         ce;
  logic [NCH-1:0]               eff;
  logic [NF_W-1:0]              nf, nd;
  logic [MIX_W-1:0]             mix;
  logic [OUT_W-1:0]             raw;
  logic [7:0]                   line8;
  logic                         unused_line_lsb;

  assign ce              = (dcnt_q == DCNT_W'(DECIM - 1));
  assign eff             = pulses & ~chan_mute;
  assign line8           = {~linein[15], linein[14:8]};
  assign unused_line_lsb = ^linein[7:0];

  // Decimator, moving-average update and mix, all advancing only on ce
  always_comb begin
    dcnt_d       = ce ? '0 : dcnt_q + DCNT_W'(1);
    dly_d        = dly_q;
    sum_d        = sum_q;
    audio_out_d  = audio_out_q;
    clip_d       = clip_q;
    sample_stb_d = ce;
    nf           = '0;
    nd           = '0;
    mix          = '0;
    raw          = '0;

    for (int i = 0; i < NCH; i++) begin
      if (eff[i]) begin
        if (FILT_MASK[i]) nf = nf + NF_W'(1);
        else              nd = nd + NF_W'(1);
      end
    end

    if (ce) begin
      dly_d[0] = nf;
      for (int i = 1; i < DEPTH; i++) dly_d[i] = dly_q[i-1];
      // Running sum: add newest, drop oldest; never underflows
      sum_d = sum_q + SUM_W'(nf) - SUM_W'(dly_q[DEPTH-1]);

      mix = (MIX_W'(sum_d) << (CH_SHIFT - LOG2DEPTH))
          + (MIX_W'(nd)    << CH_SHIFT)
          + (MIX_W'(pcm)   << PCM_SHIFT);

      if (|mix[MIX_W-1:OUT_W]) begin
        raw    = '1;
        clip_d = 1'b1;
      end else begin
        raw    = mix[OUT_W-1:0];
        clip_d = 1'b0;
      end
      if (OUT_SIGNED) raw[OUT_W-1] = ~raw[OUT_W-1];
      audio_out_d = raw;
    end
  end

  // Schmitt comparator: state-dependent thresholds, holds inside the band
  always_comb begin
    tapein_d = tapein_q;
    if (!tapein_q && ({1'b0, line8} >= TAPE_HI)) tapein_d = 1'b1;
    else if (tapein_q && ({1'b0, line8} <= TAPE_LO)) tapein_d = 1'b0;
  end

  always_ff @(posedge clk18 or negedge reset_n) begin
    if (!reset_n) begin
      dcnt_q       <= '0;
      dly_q        <= '0;
      sum_q        <= '0;
      audio_out_q  <= OUT_RST;
      clip_q       <= 1'b0;
      sample_stb_q <= 1'b0;
      tapein_q     <= 1'b0;
    end else begin
      dcnt_q       <= dcnt_d;
      dly_q        <= dly_d;
      sum_q        <= sum_d;
      audio_out_q  <= audio_out_d;
      clip_q       <= clip_d;
      sample_stb_q <= sample_stb_d;
      tapein_q     <= tapein_d;
    end
  end

  assign audio_out  = audio_out_q;
  assign clip       = clip_q;
  assign sample_stb = sample_stb_q;
  assign tapein     = tapein_q;

endmodule

// File: tb/tb_soundmix_ma.sv
// Directed self-checking bench for soundmix_ma: default build, a high-gain build that clips,
// and an offset-to-signed build.
module tb_soundmix_ma;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [3:0]  a_pulses, a_mute, b_pulses, b_mute, c_pulses, c_mute;
  logic [7:0]  a_pcm, b_pcm, c_pcm;
  logic [15:0] a_line, b_line, c_line;
  logic [15:0] a_out, b_out, c_out;
  logic        a_stb, b_stb, c_stb, a_clip, b_clip, c_clip, a_tape, b_tape, c_tape;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  soundmix_ma u_a (
    .clk18(clk), .reset_n(reset_n), .pulses(a_pulses), .chan_mute(a_mute), .pcm(a_pcm),
    .linein(a_line), .audio_out(a_out), .sample_stb(a_stb), .clip(a_clip), .tapein(a_tape));

  soundmix_ma #(.DECIM(8), .CH_SHIFT(14)) u_b (
    .clk18(clk), .reset_n(reset_n), .pulses(b_pulses), .chan_mute(b_mute), .pcm(b_pcm),
    .linein(b_line), .audio_out(b_out), .sample_stb(b_stb), .clip(b_clip), .tapein(b_tape));

  soundmix_ma #(.DECIM(8), .OUT_SIGNED(1'b1)) u_c (
    .clk18(clk), .reset_n(reset_n), .pulses(c_pulses), .chan_mute(c_mute), .pcm(c_pcm),
    .linein(c_line), .audio_out(c_out), .sample_stb(c_stb), .clip(c_clip), .tapein(c_tape));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance to the next strobe of the selected instance; returns posedges consumed
  task automatic next_stb(input int which, input string tag, output int n);
    logic s;
    n = 0;
    s = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      case (which)
        0:       s = a_stb;
        1:       s = b_stb;
        default: s = c_stb;
      endcase
    end while (!s && n < 600);
    if (!s) check({tag, "_timeout"}, 32'(s), 32'd1);
  endtask

  task automatic strobe_a(input string tag, input logic [15:0] exp);
    int n;
    next_stb(0, tag, n);
    check(tag, 32'(a_out), 32'(exp));
  endtask

  initial begin
    int n;
    a_pulses = '1; a_mute = '1; a_pcm = '1; a_line = '1;
    b_pulses = '0; b_mute = '0; b_pcm = '0; b_line = '0;
    c_pulses = '0; c_mute = '0; c_pcm = '0; c_line = '0;

    // Reset with all inputs high
    repeat (3) @(posedge clk);
    #1;
    check("rst_out",    32'(a_out),  32'd0);
    check("rst_stb",    32'(a_stb),  32'd0);
    check("rst_tape",   32'(a_tape), 32'd0);
    check("rst_clip_b", 32'(b_clip), 32'd0);
    check("rst_signed", 32'(c_out),  32'h8000);

    @(negedge clk);
    reset_n = 1'b1;
    a_pulses = 4'b0001; a_mute = '0; a_pcm = '0; a_line = 16'h0000;
    @(posedge clk); #1;
    check("post_rel_out", 32'(a_out), 32'd0);
    check("post_rel_stb", 32'(a_stb), 32'd0);
    next_stb(0, "first_stb", n);
    check("first_stb_cycle", 32'(n + 1), 32'd256);
    check("ramp1", 32'(a_out), 32'd1024);
    @(posedge clk); #1;
    check("stb_one_cycle", 32'(a_stb), 32'd0);
    strobe_a("ramp2", 16'd2048);
    strobe_a("ramp3", 16'd3072);
    strobe_a("ramp4", 16'd4096);
    strobe_a("steady", 16'd4096);

    a_pulses = 4'b0000;
    strobe_a("decay1", 16'd3072);
    strobe_a("decay2", 16'd2048);
    strobe_a("decay3", 16'd1024);
    strobe_a("decay4", 16'd0);

    // Glitch fully between ce edges must be ignored; output holds meanwhile
    a_pulses = 4'b1111;
    repeat (20) @(posedge clk);
    #1;
    check("hold_out", 32'(a_out), 32'd0);
    check("hold_stb", 32'(a_stb), 32'd0);
    a_pulses = 4'b0000;
    strobe_a("glitch_ignored", 16'd0);

    a_pulses = 4'b1000;
    strobe_a("direct", 16'd4096);
    a_pcm = 8'hFF;
    strobe_a("direct_pcm", 16'd12256);
    check("direct_pcm_clip", 32'(a_clip), 32'd0);
    a_pcm = 8'h00; a_mute = 4'b1000;
    strobe_a("muted", 16'd0);
    a_mute = 4'b0000; a_pulses = 4'b0111;
    strobe_a("filt_all1", 16'd3072);
    strobe_a("filt_all2", 16'd6144);
    strobe_a("filt_all3", 16'd9216);
    strobe_a("filt_all4", 16'd12288);

    // Reset mid-period discards the filter history
    repeat (50) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_out", 32'(a_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    next_stb(0, "midrst_stb", n);
    check("midrst_cycle", 32'(n), 32'd256);
    check("midrst_first", 32'(a_out), 32'd3072);

    // Tape comparator around midpoint 128 with hysteresis 4
    a_line = 16'h0000;
    repeat (2) @(posedge clk); #1;
    check("tape_mid", 32'(a_tape), 32'd0);
    a_line = 16'h0300;
    repeat (2) @(posedge clk); #1;
    check("tape_131", 32'(a_tape), 32'd0);
    a_line = 16'h0400;
    repeat (2) @(posedge clk); #1;
    check("tape_132", 32'(a_tape), 32'd1);
    a_line = 16'h0000;
    repeat (2) @(posedge clk); #1;
    check("tape_back_mid", 32'(a_tape), 32'd1);
    a_line = 16'hFD00;
    repeat (2) @(posedge clk); #1;
    check("tape_125", 32'(a_tape), 32'd1);
    a_line = 16'hFC00;
    repeat (2) @(posedge clk); #1;
    check("tape_124", 32'(a_tape), 32'd0);

    // High-gain build: saturates, then recovers
    next_stb(1, "b_sync", n);
    b_pulses = 4'b1111; b_pcm = 8'hFF;
    next_stb(1, "b_up1", n);
    check("b_up1", 32'(b_out), 32'd36832);
    check("b_up1_clip", 32'(b_clip), 32'd0);
    next_stb(1, "b_up2", n);
    check("b_up2", 32'(b_out), 32'd49120);
    next_stb(1, "b_up3", n);
    check("b_up3", 32'(b_out), 32'd61408);
    next_stb(1, "b_up4", n);
    check("b_sat", 32'(b_out), 32'hFFFF);
    check("b_sat_clip", 32'(b_clip), 32'd1);
    b_pulses = 4'b0000; b_pcm = 8'h00;
    next_stb(1, "b_dn1", n);
    check("b_dn1", 32'(b_out), 32'd36864);
    check("b_dn1_clip", 32'(b_clip), 32'd0);
    next_stb(1, "b_dn2", n);
    next_stb(1, "b_dn3", n);
    next_stb(1, "b_dn4", n);
    check("b_zero", 32'(b_out), 32'd0);
    check("b_zero_clip", 32'(b_clip), 32'd0);

    // Signed output build
    next_stb(2, "c_sync", n);
    check("c_zero", 32'(c_out), 32'h8000);
    c_pulses = 4'b1000;
    next_stb(2, "c_direct", n);
    check("c_direct", 32'(c_out), 32'h9000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
